// File: rtl/flip_sched_pkg.sv
// flip_sched_pkg: shared command record, scheduler state encoding and default watchdog limit for flip_scheduler
package flip_sched_pkg;
  localparam int CMD_ADDR_W = 8;
  localparam int CMD_IDX_W = 2;
  localparam int DEFAULT_TIMEOUT = 64;
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_IDX_W-1:0] r1;
    logic [CMD_IDX_W-1:0] r2;
    logic [CMD_IDX_W-1:0] c1;
    logic [CMD_IDX_W-1:0] c2;
  } flip_cmd_t;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RETIRE} sched_state_t;
endpackage

// File: rtl/flip_cmd_fifo.sv
// flip_cmd_fifo: DEPTH-entry synchronous command FIFO (push/din in, pop in, dout = head, full/empty out; pointers carry an extra wrap bit)
module flip_cmd_fifo import flip_sched_pkg::*; #(
  parameter type T = flip_cmd_t,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/flip_scheduler.sv
// flip_scheduler: buffers flip commands (cmd_valid/cmd_ready/cmd_*) and issues them one at a time to the flip controller (fc_start/fc_*/fc_done), reporting busy/done_count/skip_count/err_timeout; FLIP_SCHED_WATCHDOG_EN builds the WAIT timeout
module flip_scheduler import flip_sched_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int IDX_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [IDX_WIDTH-1:0]  cmd_r1,
  input  logic [IDX_WIDTH-1:0]  cmd_r2,
  input  logic [IDX_WIDTH-1:0]  cmd_c1,
  input  logic [IDX_WIDTH-1:0]  cmd_c2,
  output logic                  fc_start,
  output logic [ADDR_WIDTH-1:0] fc_base_addr,
  output logic [IDX_WIDTH-1:0]  fc_r1,
  output logic [IDX_WIDTH-1:0]  fc_r2,
  output logic [IDX_WIDTH-1:0]  fc_c1,
  output logic [IDX_WIDTH-1:0]  fc_c2,
  input  logic                  fc_done,
  output logic                  busy,
  output logic [7:0]            done_count,
  output logic [7:0]            skip_count,
  output logic                  err_timeout
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_WIDTH-1:0] r1;
    logic [IDX_WIDTH-1:0] r2;
    logic [IDX_WIDTH-1:0] c1;
    logic [IDX_WIDTH-1:0] c2;
  } cmd_t;
  cmd_t in_cmd, head;
  sched_state_t state;
  logic full, empty, push, pop, degen, timeout;
  assign in_cmd = '{addr: cmd_addr, r1: cmd_r1, r2: cmd_r2, c1: cmd_c1, c2: cmd_c2};
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  assign degen = (head.r1 == head.r2) || (head.c1 == head.c2);
  assign pop = (state == S_CHECK && degen) || state == S_RETIRE || timeout;
  assign fc_start = state == S_ISSUE;
  assign busy = !empty || state != S_IDLE;
  assign {fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2} = (state == S_IDLE) ? '0 : head;
  flip_cmd_fifo #(.T(cmd_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(in_cmd),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      done_count <= '0;
      skip_count <= '0;
    end else
      case (state)
        S_IDLE: if (!empty) state <= S_CHECK;
        S_CHECK: begin
          state <= degen ? S_IDLE : S_ISSUE;
          if (degen) skip_count <= skip_count + 8'd1;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: state <= fc_done ? S_RETIRE : timeout ? S_IDLE : S_WAIT;
        S_RETIRE: begin
          state <= S_IDLE;
          done_count <= done_count + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
`ifdef FLIP_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic err_q;
  assign timeout = state == S_WAIT && !fc_done && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1);
  assign err_timeout = err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wd_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_flip_scheduler.sv
// tb_flip_scheduler: directed scoreboard bench for flip_scheduler; issued operands are checked in order against commands queued when driven
module tb_flip_scheduler;
  import flip_sched_pkg::*;
  logic clk = 0, reset = 0, cmd_valid = 0, fc_done = 0;
  logic [7:0] cmd_addr = '0;
  logic [1:0] cmd_r1 = '0, cmd_r2 = '0, cmd_c1 = '0, cmd_c2 = '0;
  logic cmd_ready, fc_start, busy, err_timeout;
  logic [7:0] fc_base_addr, done_count, skip_count;
  logic [1:0] fc_r1, fc_r2, fc_c1, fc_c2;
  int checks = 0, errors = 0, cyc = 0, issued = 0, start_cyc = 0, acc_cyc = 0, pulses = 0;
  int base, k;
  flip_cmd_t exp_q[$];
  flip_cmd_t e;

  flip_scheduler #(.DEPTH(4), .ADDR_WIDTH(8), .IDX_WIDTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_r1(cmd_r1), .cmd_r2(cmd_r2), .cmd_c1(cmd_c1), .cmd_c2(cmd_c2),
    .fc_start(fc_start), .fc_base_addr(fc_base_addr), .fc_r1(fc_r1), .fc_r2(fc_r2),
    .fc_c1(fc_c1), .fc_c2(fc_c2), .fc_done(fc_done), .busy(busy),
    .done_count(done_count), .skip_count(skip_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk)
    if (reset && fc_start) begin
      issued++;
      start_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_start", {31'd0, fc_start}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("issue_addr", {24'd0, fc_base_addr}, {24'd0, e.addr});
        chk("issue_rect", {24'd0, fc_r1, fc_r2, fc_c1, fc_c2}, {24'd0, e.r1, e.r2, e.c1, e.c2});
      end
    end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [1:0] r1, input logic [1:0] r2,
                      input logic [1:0] c1, input logic [1:0] c2);
    int b = 60;
    cmd_addr = a; cmd_r1 = r1; cmd_r2 = r2; cmd_c1 = c1; cmd_c2 = c2;
    cmd_valid = 1;
    if (r1 != r2 && c1 != c2) exp_q.push_back('{addr: a, r1: r1, r2: r2, c1: c1, c2: c2});
    while (!cmd_ready && b > 0) begin
      step();
      b--;
    end
    chk("accept_bound", {31'd0, cmd_ready}, 32'd1);
    step();
    acc_cyc = cyc;
    cmd_valid = 0;
  endtask

  task automatic wait_issue(input int target);
    int b = 100;
    while (issued < target && b > 0) begin
      step();
      b--;
    end
    chk("issue_bound", {31'd0, issued >= target}, 32'd1);
  endtask

  task automatic done_pulse();
    fc_done = 1;
    step();
    fc_done = 0;
    pulses++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      wait_issue(pulses + 1);
      step(2);
      done_pulse();
    end
  endtask

  task automatic wait_idle();
    int b = 200;
    while (busy && b > 0) begin
      step();
      b--;
    end
    chk("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    step(3);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_fc_start", {31'd0, fc_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_counts", {16'd0, done_count, skip_count}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_operands", {16'd0, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2}, 32'd0);
    reset = 1;
    step(2);

    send(8'h10, 2'd0, 2'd2, 2'd1, 2'd3);
    wait_issue(1);
    chk("start_latency", start_cyc - acc_cyc, 32'd2);
    chk("start_one_cycle", {31'd0, fc_start}, 32'd0);
    chk("hold_addr", {24'd0, fc_base_addr}, 32'h10);
    step(4);
    done_pulse();
    step();
    chk("single_done", {24'd0, done_count}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 2'd0, 2'd3, 2'd1, 2'd2);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_addr = 8'h34; cmd_r1 = 2'd3; cmd_r2 = 2'd0; cmd_c1 = 2'd2; cmd_c2 = 2'd1;
    cmd_valid = 1;
    exp_q.push_back('{addr: 8'h34, r1: 2'd3, r2: 2'd0, c1: 2'd2, c2: 2'd1});
    step(3);
    chk("stall_ready", {31'd0, cmd_ready}, 32'd0);
    done_pulse();
    chk("retire_ready", {31'd0, cmd_ready}, 32'd0);
    chk("retire_count_pre", {24'd0, done_count}, 32'd1);
    step();
    chk("retire_count_post", {24'd0, done_count}, 32'd2);
    chk("retire_ready_post", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 0;
    drain(4);
    wait_idle();
    chk("batch_done", {24'd0, done_count}, 32'd6);
    chk("batch_scoreboard", exp_q.size(), 32'd0);

    send(8'h20, 2'd1, 2'd1, 2'd0, 2'd3);
    step(2);
    chk("skip_count", {24'd0, skip_count}, 32'd1);
    chk("skip_idle", {31'd0, busy}, 32'd0);
    send(8'h21, 2'd0, 2'd1, 2'd2, 2'd3);
    drain(1);
    step();
    chk("after_skip_done", {16'd0, done_count, skip_count}, {16'd0, 8'd7, 8'd1});

    send(8'h40, 2'd0, 2'd1, 2'd0, 2'd1);
    send(8'h41, 2'd1, 2'd2, 2'd1, 2'd2);
    wait_issue(pulses + 1);
    step(2);
    done_pulse();
    send(8'h42, 2'd2, 2'd3, 2'd2, 2'd3);
    send(8'h43, 2'd3, 2'd2, 2'd3, 2'd2);
    chk("pushpop_ready_occ3", {31'd0, cmd_ready}, 32'd1);
    send(8'h44, 2'd2, 2'd1, 2'd2, 2'd1);
    chk("pushpop_ready_occ4", {31'd0, cmd_ready}, 32'd0);
    drain(4);
    wait_idle();
    chk("pushpop_done", {24'd0, done_count}, 32'd12);
    chk("pushpop_scoreboard", exp_q.size(), 32'd0);

    base = issued;
    send(8'h50, 2'd0, 2'd1, 2'd2, 2'd3);
    send(8'h51, 2'd1, 2'd0, 2'd3, 2'd2);
    send(8'h52, 2'd2, 2'd0, 2'd1, 2'd0);
    wait_issue(base + 1);
    step(2);
    reset = 0;
    #2;
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_counts", {16'd0, done_count, skip_count}, 32'd0);
    chk("mid_rst_operands", {16'd0, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2}, 32'd0);
    exp_q.delete();
    step();
    reset = 1;
    step();
    done_pulse();
    step(4);
    chk("late_done_ignored", {24'd0, done_count}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef FLIP_SCHED_WATCHDOG_EN
    base = issued;
    send(8'h60, 2'd0, 2'd2, 2'd0, 2'd2);
    send(8'h61, 2'd1, 2'd3, 2'd1, 2'd3);
    wait_issue(base + 1);
    k = start_cyc;
    while (cyc < k + 8) step();
    chk("wd_before_limit", {31'd0, err_timeout}, 32'd0);
    step();
    chk("wd_err_set", {31'd0, err_timeout}, 32'd1);
    chk("wd_done_unchanged", {24'd0, done_count}, 32'd0);
    wait_issue(base + 2);
    chk("wd_next_issue", start_cyc - k, 32'd11);
    wait_idle();
    chk("wd_err_sticky", {31'd0, err_timeout}, 32'd1);
    chk("wd_final_done", {24'd0, done_count}, 32'd0);
`else
    send(8'h60, 2'd0, 2'd2, 2'd0, 2'd2);
    wait_issue(issued + 1);
    step(20);
    chk("no_wd_err", {31'd0, err_timeout}, 32'd0);
    chk("no_wd_hold", {31'd0, busy}, 32'd1);
    done_pulse();
    step();
    chk("no_wd_done", {24'd0, done_count}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flip_scheduler.md
# flip_scheduler

Queues rectangle-flip commands and issues them one at a time to the existing flip controller (start / done handshake). It replaces the manual single-shot `start` with a buffered command stream, so software or an upstream planner can post a batch of flips and track completion. It sits between the command source and the flip controller. It never touches matrix memory directly.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries. Must be a power of two and at least 2.
- `ADDR_WIDTH`, 8: base address width.
- `IDX_WIDTH`, 2: row/column index width.
- `TIMEOUT_CYCLES`, 64: watchdog limit. Used only when the watchdog is compiled in.

Ports:
- `clk`  in  1: clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: FIFO not full.
- `cmd_addr`  in  ADDR_WIDTH: matrix base address.
- `cmd_r1`, `cmd_r2`, `cmd_c1`, `cmd_c2`  in  IDX_WIDTH each: rectangle corners.
- `fc_start`  out  1: one-cycle start pulse to the flip controller.
- `fc_base_addr`  out  ADDR_WIDTH: operand to the controller.
- `fc_r1`, `fc_r2`, `fc_c1`, `fc_c2`  out  IDX_WIDTH each: operands to the controller.
- `fc_done`  in  1: controller completion pulse.
- `busy`  out  1: FIFO non-empty or state not IDLE.
- `done_count`  out  8: flips completed, wraps modulo 256.
- `skip_count`  out  8: degenerate commands retired without issue, wraps modulo 256.
- `err_timeout`  out  1: sticky watchdog flag.

## Operation
- A push happens when `cmd_valid && cmd_ready`. `cmd_ready = !full`. There is no bypass.
  - When the FIFO is full and a pop happens in the same cycle, `cmd_ready` stays 0 that cycle.
- FSM states are IDLE, CHECK, ISSUE, WAIT, RETIRE.
- IDLE: if the FIFO is not empty, go to CHECK.
- CHECK: examine the head entry.
  - If `r1==r2` or `c1==c2`, the command is degenerate. Pop it, increment `skip_count`, go to IDLE. `fc_start` is never asserted for it.
  - Otherwise go to ISSUE.
- ISSUE: `fc_start=1` for exactly this one cycle, then go to WAIT.
- WAIT: stay until `fc_done=1`, then go to RETIRE.
  - `fc_done` is ignored in every other state.
- RETIRE: pop the head, increment `done_count`, go to IDLE.
- `fc_base_addr` and `fc_r*`/`fc_c*` are driven from the FIFO head. They are held stable from CHECK through RETIRE.
- Push and pop in the same cycle are legal whenever the FIFO is not full. Occupancy is unchanged.
- `fc_start` is decoded from the registered state only, so it is glitch-free.

## Timing
- Reset values:
  - `cmd_ready=1`, `fc_start=0`, `busy=0`, `done_count=0`, `skip_count=0`, `err_timeout=0`.
  - Operand outputs are 0.
  - FIFO is empty; state is IDLE.
- Command accepted at edge N into an empty, IDLE scheduler:
  - CHECK at N+1.
  - `fc_start` high in the cycle following edge N+2.
- `fc_done` sampled at edge M: RETIRE in the cycle after M; the next command reaches ISSUE no earlier than M+3.
- Degenerate command: retired 2 cycles after it reaches the head.
- `done_count` and `skip_count` update at the RETIRE/CHECK edge.
- Reset asserted mid-operation:
  - Everything returns to reset values immediately; queued commands are discarded.
  - The flip controller shares the reset, so no in-flight handshake survives.

## Configuration
- `FLIP_SCHED_WATCHDOG_EN` defined:
  - A cycle counter runs in WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `fc_done`: set `err_timeout` (sticky until reset), pop the head without incrementing `done_count`, go to IDLE.
  - A `fc_done` arriving later is ignored unless the FSM is in WAIT for a newly issued command.
- Not defined:
  - No counter is built and `err_timeout` is tied to 0.
  - WAIT holds indefinitely.

## Structure
- Package `flip_sched_pkg` holds:
  - `flip_cmd_t` packed struct {addr, r1, r2, c1, c2}.
  - `sched_state_t` enum.
  - A `DEFAULT_TIMEOUT` constant.
- Sub-module `flip_cmd_fifo`: synchronous FIFO of `flip_cmd_t`, DEPTH entries, with full/empty flags and wrapping pointers plus an extra wrap bit.
- The scheduler FSM, counters and watchdog live in `flip_scheduler`.

## Test plan
- Single command {addr=0x10, r1=0, r2=2, c1=1, c2=3} into an idle scheduler:
  - Expect `fc_start` one cycle, 2 cycles after acceptance, with matching operands.
  - `fc_done` 5 cycles later gives `done_count=1` and `busy=0`.
- Push 5 commands back-to-back with DEPTH=4 and the controller stalled:
  - `cmd_ready` drops after the 4th.
  - The 5th is accepted only after the first RETIRE.
  - All 5 issue in order.
- Degenerate command r1=r2=1:
  - No `fc_start`, `skip_count=1`.
  - The following valid command issues normally.
- Push and pop in the same cycle at occupancy 2: occupancy stays 2 and ordering is preserved.
- Reset low during WAIT with 3 queued:
  - All outputs return to reset values.
  - A later `fc_done` does not change `done_count`.
- With `FLIP_SCHED_WATCHDOG_EN` and `TIMEOUT_CYCLES=8`, never assert `fc_done`:
  - `err_timeout=1` after 8 WAIT cycles.
  - The head is dropped, the next command issues, and `done_count` is unchanged.
